// File: rtl/fv_qed_commit_tracker_if.sv
// Commit-strobe bus between the FV bind layer and the QED commit tracker.
// master drives retire strobes and stall; slave returns counts and status flags.
interface fv_qed_commit_tracker_if #(
    parameter int MAX_COMMIT = 2,
    parameter int CNT_WIDTH  = 16
);
    logic [MAX_COMMIT:1]  commit;
    logic [MAX_COMMIT:1]  commit_is_dup;
    logic                 stall;
    logic [CNT_WIDTH-1:0] orig_count;
    logic [CNT_WIDTH-1:0] dup_count;
    logic                 qed_ready;
    logic                 qed_error;
    logic                 cnt_overflow;
    logic                 wdog_fire;

    modport master (
        output commit, commit_is_dup, stall,
        input  orig_count, dup_count, qed_ready, qed_error, cnt_overflow, wdog_fire
    );

    modport slave (
        input  commit, commit_is_dup, stall,
        output orig_count, dup_count, qed_ready, qed_error, cnt_overflow, wdog_fire
    );
endinterface

// File: rtl/fv_qed_commit_tracker.sv
// Counts retired original/duplicate QED instructions and reports MATCH, ordering errors and saturation.
// Optional idle watchdog is built only when FV_COMMIT_WATCHDOG_EN is defined.
module fv_qed_commit_tracker #(
    parameter int MAX_COMMIT  = 2,
    parameter int CNT_WIDTH   = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    fv_qed_commit_tracker_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_MATCH, S_SAT, S_ERROR} state_t;

    localparam logic [CNT_WIDTH:0] ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_orig, r_dup;
    logic                 r_ready, r_err, r_ovf;

    logic [CNT_WIDTH:0]   w_n_orig, w_n_dup, w_sum_orig, w_sum_dup;
    logic [CNT_WIDTH-1:0] w_nx_orig, w_nx_dup;
    logic                 w_sat_orig, w_sat_dup, w_sat_any;

    always_comb begin
        w_n_orig = '0;
        w_n_dup  = '0;
        for (int i = 1; i <= MAX_COMMIT; i++) begin
            if (bus.commit[i]) begin
                if (bus.commit_is_dup[i]) w_n_dup  = w_n_dup + ONE;
                else                      w_n_orig = w_n_orig + ONE;
            end
        end
        w_sum_orig = {1'b0, r_orig} + w_n_orig;
        w_sum_dup  = {1'b0, r_dup} + w_n_dup;
        // Carry out of the widened add means the count passed all-ones.
        w_sat_orig = w_sum_orig[CNT_WIDTH];
        w_sat_dup  = w_sum_dup[CNT_WIDTH];
        w_sat_any  = w_sat_orig | w_sat_dup;
        w_nx_orig  = w_sat_orig ? '1 : w_sum_orig[CNT_WIDTH-1:0];
        w_nx_dup   = w_sat_dup  ? '1 : w_sum_dup[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_orig  <= '0;
            r_dup   <= '0;
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_orig <= w_nx_orig;
            r_dup  <= w_nx_dup;
            if (w_sat_any) r_ovf <= 1'b1;
            if (r_state == S_ERROR || w_nx_dup > w_nx_orig) begin
                r_state <= S_ERROR;
                r_ready <= 1'b0;
                r_err   <= 1'b1;
            end else if (r_state == S_SAT || w_sat_any) begin
                r_state <= S_SAT;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_nx_orig == w_nx_dup && w_nx_orig != '0) begin
                r_state <= S_MATCH;
                r_ready <= 1'b1;
                r_err   <= 1'b0;
            end else if (w_nx_orig != '0) begin
                r_state <= S_RUN;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                r_state <= S_IDLE;
                r_ready <= 1'b0;
                r_err   <= 1'b0;
            end
        end
    end

    assign bus.orig_count   = r_orig;
    assign bus.dup_count    = r_dup;
    assign bus.qed_ready    = r_ready;
    assign bus.qed_error    = r_err;
    assign bus.cnt_overflow = r_ovf;

`ifdef FV_COMMIT_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LIM = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WONE     = WW'(1);

    logic [WW-1:0] r_idle;
    logic          r_wdog;

    // Idle time is only meaningful while a QED program is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idle <= '0;
            r_wdog <= 1'b0;
        end else if (|bus.commit) begin
            r_idle <= '0;
        end else if (!bus.stall && (r_state == S_RUN || r_state == S_MATCH)
                     && r_idle != WDOG_LIM) begin
            r_idle <= r_idle + WONE;
            if (r_idle + WONE == WDOG_LIM) r_wdog <= 1'b1;
        end
    end

    assign bus.wdog_fire = r_wdog;
`else
    logic w_unused_stall;
    assign w_unused_stall = bus.stall;
    assign bus.wdog_fire  = 1'b0;
`endif
endmodule

// File: tb/tb_fv_qed_commit_tracker.sv
// Self-checking bench for fv_qed_commit_tracker: directed table, corner sequences and a
// randomized run against a count-based reference model (CNT_WIDTH=4, WDOG_CYCLES=8).
module tb_fv_qed_commit_tracker;
    localparam int MC   = 2;
    localparam int CW   = 4;
    localparam int WD   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fv_qed_commit_tracker_if #(.MAX_COMMIT(MC), .CNT_WIDTH(CW)) bus ();

    fv_qed_commit_tracker #(.MAX_COMMIT(MC), .CNT_WIDTH(CW), .WDOG_CYCLES(WD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain counts plus sticky flags.
    int m_orig, m_dup, m_idle;
    bit m_err, m_sat, m_ovf, m_wdog;

    function automatic bit m_ready();
        return !m_err && !m_sat && m_orig == m_dup && m_orig != 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " orig"},  int'(bus.orig_count),   m_orig);
        check({tag, " dup"},   int'(bus.dup_count),    m_dup);
        check({tag, " ready"}, int'(bus.qed_ready),    int'(m_ready()));
        check({tag, " error"}, int'(bus.qed_error),    int'(m_err));
        check({tag, " ovf"},   int'(bus.cnt_overflow), int'(m_ovf));
        check({tag, " wdog"},  int'(bus.wdog_fire),    int'(m_wdog));
    endtask

    task automatic model_step(input logic [MC:1] c, input logic [MC:1] d, input logic s);
        int o, u;
        bit active, sat_now;
        active  = !m_err && !m_sat && m_orig != 0;
        o       = m_orig + $countones(c & ~d);
        u       = m_dup  + $countones(c & d);
        sat_now = 0;
        if (o > CMAX) begin o = CMAX; sat_now = 1; end
        if (u > CMAX) begin u = CMAX; sat_now = 1; end
        if (u > o) m_err = 1;
        if (sat_now) begin m_sat = 1; m_ovf = 1; end
        m_orig = o;
        m_dup  = u;
`ifdef FV_COMMIT_WATCHDOG_EN
        if (c != 0) m_idle = 0;
        else if (!s && active && m_idle < WD) begin
            m_idle++;
            if (m_idle == WD) m_wdog = 1;
        end
`else
        active = active & s;
`endif
    endtask

    // Called at #1 after a posedge; applies one cycle of input and compares against the model.
    task automatic step(input logic [MC:1] c, input logic [MC:1] d, input logic s, input string tag);
        bus.commit        = c;
        bus.commit_is_dup = d;
        bus.stall         = s;
        @(posedge clk);
        model_step(c, d, s);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        bus.commit        = 2'b11;
        bus.commit_is_dup = 2'b01;
        bus.stall         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        m_orig = 0; m_dup = 0; m_idle = 0;
        m_err = 0; m_sat = 0; m_ovf = 0; m_wdog = 0;
        check_model("reset");
    endtask

    typedef struct {
        logic [MC:1] c;
        logic [MC:1] d;
        int          e_orig;
        int          e_dup;
        logic        e_ready;
    } vec_t;

    vec_t tbl[8];

    initial begin
        bit exp_wd;
        reset             = 1'b1;
        bus.commit        = '0;
        bus.commit_is_dup = '0;
        bus.stall         = 1'b0;

        tbl[0] = '{2'b01, 2'b00, 1, 0, 1'b0};
        tbl[1] = '{2'b10, 2'b00, 2, 0, 1'b0};
        tbl[2] = '{2'b01, 2'b10, 3, 0, 1'b0};
        tbl[3] = '{2'b01, 2'b01, 3, 1, 1'b0};
        tbl[4] = '{2'b10, 2'b10, 3, 2, 1'b0};
        tbl[5] = '{2'b01, 2'b01, 3, 3, 1'b1};
        tbl[6] = '{2'b01, 2'b00, 4, 3, 1'b0};
        tbl[7] = '{2'b11, 2'b10, 5, 4, 1'b0};

        // Reset with commits asserted, then the match sequence from the table
        do_reset();
        check("reset orig const", int'(bus.orig_count), 0);
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].c, tbl[i].d, 1'b0, "tbl");
            check($sformatf("tbl[%0d] orig", i),  int'(bus.orig_count), tbl[i].e_orig);
            check($sformatf("tbl[%0d] dup", i),   int'(bus.dup_count),  tbl[i].e_dup);
            check($sformatf("tbl[%0d] ready", i), int'(bus.qed_ready),  int'(tbl[i].e_ready));
        end

        // Dual slot: one original and one duplicate in the same cycle
        do_reset();
        step(2'b11, 2'b10, 1'b0, "dual");
        check("dual orig", int'(bus.orig_count), 1);
        check("dual dup",  int'(bus.dup_count),  1);
        check("dual ready", int'(bus.qed_ready), 1);
        step(2'b00, 2'b00, 1'b0, "dual hold");
        check("dual hold ready", int'(bus.qed_ready), 1);

        // Error: duplicate first, sticky even when counts later match
        do_reset();
        step(2'b01, 2'b01, 1'b0, "err");
        check("err flag", int'(bus.qed_error), 1);
        step(2'b01, 2'b00, 1'b0, "err eq");
        check("err eq ready", int'(bus.qed_ready), 0);
        check("err eq flag",  int'(bus.qed_error), 1);
        step(2'b11, 2'b00, 1'b0, "err more");
        check("err accum orig", int'(bus.orig_count), 3);

        // Saturation: 16 originals on a 4-bit counter, then matching duplicates
        do_reset();
        for (int i = 0; i < 15; i++) step(2'b01, 2'b00, 1'b0, "sat fill");
        check("sat pre ovf", int'(bus.cnt_overflow), 0);
        step(2'b01, 2'b00, 1'b0, "sat hit");
        check("sat orig", int'(bus.orig_count), 15);
        check("sat ovf",  int'(bus.cnt_overflow), 1);
        for (int i = 0; i < 15; i++) step(2'b01, 2'b01, 1'b0, "sat dups");
        check("sat dup",   int'(bus.dup_count), 15);
        check("sat ready", int'(bus.qed_ready), 0);
        check("sat error", int'(bus.qed_error), 0);

        // Watchdog: 8 unstalled idle cycles with stalls interleaved
`ifdef FV_COMMIT_WATCHDOG_EN
        exp_wd = 1'b1;
`else
        exp_wd = 1'b0;
`endif
        do_reset();
        step(2'b01, 2'b00, 1'b0, "wd orig");
        for (int i = 0; i < 7; i++) begin
            step(2'b00, 2'b00, 1'b0, "wd idle");
            step(2'b00, 2'b00, 1'b1, "wd stall");
        end
        check("wd not yet", int'(bus.wdog_fire), 0);
        step(2'b00, 2'b00, 1'b0, "wd idle8");
        check("wd fire", int'(bus.wdog_fire), int'(exp_wd));
        step(2'b01, 2'b00, 1'b0, "wd sticky");
        check("wd sticky", int'(bus.wdog_fire), int'(exp_wd));

        // Randomized epochs, each starting from reset
        for (int e = 0; e < 12; e++) begin
            do_reset();
            for (int k = 0; k < 40; k++) begin
                logic [MC:1] c, d;
                logic s;
                c = ($urandom_range(0, 9) < 4) ? 2'b00 : MC'($urandom);
                d = ($urandom_range(0, 3) == 0) ? MC'($urandom) : 2'b00;
                if (e % 2 == 1) d = c & MC'($urandom);
                s = ($urandom_range(0, 4) == 0);
                step(c, d, s, "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
